// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Segment codes are {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, active-low (0 = segment lit).
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Ports: Clk, Reset (sync, active-high), start (honoured in IDLE only),
//        value (binary input), busy (SHIFT or DONE), done (one cycle, bcd valid),
//        bcd (4*N_DIGITS BCD result), overflow (value >= 10^N_DIGITS, valid with done).
import ssd_pkg::*;

module bin2bcd_seq #(
  parameter int VALUE_W  = 9,
  parameter int N_DIGITS = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

  conv_state_t        state;
  logic [VALUE_W-1:0] shreg;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  always_comb begin
    adj = work;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      shreg <= '0;
      work  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= value;
            work  <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // A 1 leaving the top nibble means the value needs more digits.
          work  <= {adj[BCD_W-2:0], shreg[VALUE_W-1]};
          ovf   <= ovf | adj[BCD_W-1];
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign bcd      = work;
  assign overflow = ovf;

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment driver.
// Ports: Clk, Reset (sync, active-high), load/value/hex_mode (capture request,
//        honoured when busy=0), blank_lz (leading-zero blanking), digit_en and
//        dp_mask (per digit), busy (conversion in progress), An (active-low
//        anodes, An[0] rightmost), Seg ({Ca..Cg}, active-low), Dp (active-low).
import ssd_pkg::*;

module ssd_scan_driver #(
  parameter int N_DIGITS = 6,
  parameter int VALUE_W  = 9,
  parameter int SCAN_DIV = 262144
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                load,
  input  logic [VALUE_W-1:0]  value,
  input  logic                hex_mode,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] digit_en,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic                busy,
  output logic [N_DIGITS-1:0] An,
  output logic [6:0]          Seg,
  output logic                Dp
);

  localparam int BCD_W    = 4 * N_DIGITS;
  localparam int HEX_BITS = (VALUE_W < BCD_W) ? VALUE_W : BCD_W;
  localparam int PRE_W    = $clog2(SCAN_DIV);
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic               load_ok;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_ovf;
  logic               hex_pend;
  logic [VALUE_W-1:0] hex_val;
  logic [BCD_W-1:0]   hex_nib;
  logic [BCD_W-1:0]   disp;
  logic               disp_ovf;
  logic [PRE_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         cur_dig;
  logic               upper_zero;
  logic               lit;
  logic [N_DIGITS-1:0] an_nxt;
  logic [6:0]         seg_nxt;
  logic               dp_nxt;

  assign busy    = conv_busy | hex_pend;
  assign load_ok = load & ~busy;

  bin2bcd_seq #(
    .VALUE_W  (VALUE_W),
    .N_DIGITS (N_DIGITS)
  ) u_bcd (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (load_ok & ~hex_mode),
    .value    (value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Hex bypass: low nibbles of the captured value, zero-filled above VALUE_W.
  always_comb begin
    hex_nib = '0;
    for (int unsigned b = 0; b < HEX_BITS; b++) hex_nib[b] = hex_val[b];
  end

  always_comb begin
    cur_dig    = disp[{idx, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (disp[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    lit = digit_en[idx] & ~(blank_lz & ~disp_ovf & (idx != '0) & upper_zero);
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = disp_ovf ? SEG_DASH : hex_to_seg(cur_dig);
      dp_nxt      = ~dp_mask[idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_pend <= 1'b0;
      hex_val  <= '0;
      disp     <= '0;
      disp_ovf <= 1'b0;
      presc    <= '0;
      idx      <= '0;
      An       <= '1;
      Seg      <= SEG_BLANK;
      Dp       <= 1'b1;
    end else begin
      hex_pend <= load_ok & hex_mode;
      if (load_ok & hex_mode) hex_val <= value;

      // The display register only changes on a completed result.
      if (hex_pend) begin
        disp     <= hex_nib;
        disp_ovf <= 1'b0;
      end else if (conv_done) begin
        disp     <= conv_bcd;
        disp_ovf <= conv_ovf;
      end

      if (presc == PRE_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      An  <= an_nxt;
      Seg <= seg_nxt;
      Dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: a 4-digit and a 2-digit instance share stimulus.
module tb_ssd_scan_driver;

  localparam int W   = 10;
  localparam int DIV = 4;

  typedef struct packed {
    int          upd;   // edge at which the display register takes this value
    logic [15:0] dig;   // expected digits, nibble i = digit i
    logic        ovf;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] value = '0;
  logic         hex_mode = 1'b0;
  logic         blank_lz = 1'b1;
  logic [3:0]   digit_en = 4'hF;
  logic [3:0]   dp_mask = 4'h0;

  logic         busy4, busy2, dp4, dp2;
  logic [3:0]   an4;
  logic [1:0]   an2;
  logic [6:0]   seg4, seg2;

  int total = 0;
  int bad   = 0;

  logic [6:0] segtab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  ssd_scan_driver #(.N_DIGITS(4), .VALUE_W(W), .SCAN_DIV(DIV)) dut4 (
    .Clk(Clk), .Reset(Reset), .load(load), .value(value), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .digit_en(digit_en), .dp_mask(dp_mask),
    .busy(busy4), .An(an4), .Seg(seg4), .Dp(dp4));

  ssd_scan_driver #(.N_DIGITS(2), .VALUE_W(W), .SCAN_DIV(DIV)) dut2 (
    .Clk(Clk), .Reset(Reset), .load(load), .value(value), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .digit_en(digit_en[1:0]), .dp_mask(dp_mask[1:0]),
    .busy(busy2), .An(an2), .Seg(seg2), .Dp(dp2));

  always #5 Clk = ~Clk;

  // Digits of a value for an n-digit display, from plain arithmetic.
  function automatic exp_t predict(int n, int v, bit hex, int upd);
    exp_t e;
    int   p;
    e.upd = upd;
    e.dig = '0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      if (hex) e.dig[4*i +: 4] = 4'((v >> (4*i)) & 15);
      else     e.dig[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    e.ovf = !hex && (v >= p);
    return e;
  endfunction

  // Expected {An(4, unused bits 1), Seg, Dp} for the digit in slot idx.
  function automatic logic [11:0] expect_out(int n, exp_t c, int idx,
                                             logic [3:0] en, logic bz, logic [3:0] dpm);
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         upper_zero;
    an  = 4'hF;
    seg = 7'h7F;
    dp  = 1'b1;
    upper_zero = 1;
    for (int j = idx; j < n; j++) if (c.dig[4*j +: 4] != 4'd0) upper_zero = 0;
    if (en[idx] && !(bz && !c.ovf && idx > 0 && upper_zero)) begin
      an[idx] = 1'b0;
      seg     = c.ovf ? 7'b1111110 : segtab[c.dig[4*idx +: 4]];
      dp      = !dpm[idx];
    end
    return {an, seg, dp};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got {an,seg,dp,busy}=%b want %b", name, $time, act, req);
    end
  endtask

  // Predictor: decides acceptance of each load and queues the expected display.
  exp_t q4[$];
  exp_t q2[$];
  int   ecnt = 0;
  int   bl4 = -1, bl2 = -1;   // last edge after which busy is expected high
  bit   xb4, xb2;

  initial forever begin
    @(posedge Clk);
    ecnt++;
    if (Reset) begin
      q4.delete();
      q2.delete();
      bl4 = -1;
      bl2 = -1;
    end else if (load) begin
      if (!(ecnt - 1 <= bl4)) begin
        q4.push_back(predict(4, int'(value), hex_mode, ecnt + (hex_mode ? 1 : W + 1)));
        bl4 = hex_mode ? ecnt : ecnt + W;
      end
      if (!(ecnt - 1 <= bl2)) begin
        q2.push_back(predict(2, int'(value), hex_mode, ecnt + (hex_mode ? 1 : W + 1)));
        bl2 = hex_mode ? ecnt : ecnt + W;
      end
    end
    xb4 = (ecnt <= bl4);
    xb2 = (ecnt <= bl2);
  end

  // Monitor: every clock, compares the scanned outputs with the model.
  exp_t cur4, cur2;
  int   nscan = 0;

  initial forever begin
    logic [11:0] e4, e2;
    @(posedge Clk);
    #1;
    if (Reset) begin
      cur4  = '0;
      cur2  = '0;
      nscan = 0;
      chk("reset4", {an4, seg4, dp4, busy4}, {4'hF, 7'h7F, 1'b1, 1'b0});
      chk("reset2", {2'b11, an2, seg2, dp2, busy2}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end else begin
      while (q4.size() > 0 && q4[0].upd < ecnt) cur4 = q4.pop_front();
      while (q2.size() > 0 && q2[0].upd < ecnt) cur2 = q2.pop_front();
      e4 = expect_out(4, cur4, (nscan / DIV) % 4, digit_en, blank_lz, dp_mask);
      e2 = expect_out(2, cur2, (nscan / DIV) % 2, digit_en, blank_lz, dp_mask);
      nscan++;
      chk("scan4", {an4, seg4, dp4, busy4}, {e4, xb4});
      chk("scan2", {2'b11, an2, seg2, dp2, busy2}, {e2, xb2});
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge Clk);
  endtask

  task automatic do_load(input int v, input bit hex);
    value    = W'(v);
    hex_mode = hex;
    load     = 1'b1;
    @(negedge Clk);
    load     = 1'b0;
  endtask

  initial begin
    cyc(3);
    Reset = 1'b0;
    cyc(20);

    do_load(987, 0);
    cyc(40);

    dp_mask = 4'b0010;
    do_load(10'h2AF, 1);
    cyc(20);
    blank_lz = 1'b0;
    cyc(20);

    blank_lz = 1'b1;
    dp_mask  = 4'b0000;
    do_load(0, 0);
    cyc(30);
    digit_en = 4'b1110;
    cyc(20);
    digit_en = 4'b1111;

    do_load(100, 0);
    cyc(3);
    do_load(555, 0);
    cyc(40);

    do_load(1023, 0);
    cyc(5);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    do_load(5, 0);
    cyc(40);

    repeat (60) begin
      blank_lz = 1'($urandom_range(0, 1));
      digit_en = 4'($urandom_range(0, 15));
      dp_mask  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
      end
      do_load(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      cyc(int'($urandom_range(0, 25)));
    end
    cyc(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
